// File: rtl/axi4_if.sv
// AXI4 bus bundle; the AXI4-Lite subset plus IDs so AXI4-Lite blocks can share one port type.
// A transfer on any channel happens on a rising edge where valid and ready are both high.
interface axi4_if #(
    parameter int A = 16,
    parameter int N = 4,
    parameter int I = 1
);
    logic [I-1:0]   awid;
    logic [A-1:0]   awaddr;
    logic [2:0]     awprot;
    logic           awvalid;
    logic           awready;
    logic [N*8-1:0] wdata;
    logic [N-1:0]   wstrb;
    logic           wvalid;
    logic           wready;
    logic [I-1:0]   bid;
    logic [1:0]     bresp;
    logic           bvalid;
    logic           bready;
    logic [I-1:0]   arid;
    logic [A-1:0]   araddr;
    logic [2:0]     arprot;
    logic           arvalid;
    logic           arready;
    logic [I-1:0]   rid;
    logic [N*8-1:0] rdata;
    logic [1:0]     rresp;
    logic           rvalid;
    logic           rready;

    modport master (
        output awid, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               arid, araddr, arprot, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid
    );

    modport slave (
        input  awid, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               arid, araddr, arprot, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_fanin.sv
// Two-initiator to one-responder AXI4-Lite merge with independent round-robin
// write and read arbiters, one outstanding transaction per direction.
module axi4_lite_fanin #(
    parameter int A = 16,
    parameter int N = 4,
    parameter int I = 1
) (
    input  logic       aclk,
    input  logic       areset,
    axi4_if.slave      axi4_s [2],
    axi4_if.master     axi4_m,
    output logic [1:0] w_fsm,
    output logic [1:0] r_fsm
);
    localparam int D = N * 8;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_DATA = 2'd2} r_state_t;

    logic         s_awvalid [2];
    logic [A-1:0] s_awaddr  [2];
    logic [2:0]   s_awprot  [2];
    logic         s_wvalid  [2];
    logic [D-1:0] s_wdata   [2];
    logic [N-1:0] s_wstrb   [2];
    logic         s_bready  [2];
    logic         s_arvalid [2];
    logic [A-1:0] s_araddr  [2];
    logic [2:0]   s_arprot  [2];
    logic         s_rready  [2];
    logic         s_awready [2];
    logic         s_wready  [2];
    logic         s_bvalid  [2];
    logic [1:0]   s_bresp   [2];
    logic         s_arready [2];
    logic         s_rvalid  [2];
    logic [D-1:0] s_rdata   [2];
    logic [1:0]   s_rresp   [2];

    for (genvar i = 0; i < 2; i++) begin : g_port
        assign s_awvalid[i] = axi4_s[i].awvalid;
        assign s_awaddr[i]  = axi4_s[i].awaddr;
        assign s_awprot[i]  = axi4_s[i].awprot;
        assign s_wvalid[i]  = axi4_s[i].wvalid;
        assign s_wdata[i]   = axi4_s[i].wdata;
        assign s_wstrb[i]   = axi4_s[i].wstrb;
        assign s_bready[i]  = axi4_s[i].bready;
        assign s_arvalid[i] = axi4_s[i].arvalid;
        assign s_araddr[i]  = axi4_s[i].araddr;
        assign s_arprot[i]  = axi4_s[i].arprot;
        assign s_rready[i]  = axi4_s[i].rready;
        assign axi4_s[i].awready = s_awready[i];
        assign axi4_s[i].wready  = s_wready[i];
        assign axi4_s[i].bvalid  = s_bvalid[i];
        assign axi4_s[i].bresp   = s_bresp[i];
        assign axi4_s[i].bid     = {I{1'b0}};
        assign axi4_s[i].arready = s_arready[i];
        assign axi4_s[i].rvalid  = s_rvalid[i];
        assign axi4_s[i].rdata   = s_rdata[i];
        assign axi4_s[i].rresp   = s_rresp[i];
        assign axi4_s[i].rid     = {I{1'b0}};
        wire unused_ids = ^{axi4_s[i].awid, axi4_s[i].arid};
    end
    wire unused_dn_ids = ^{axi4_m.bid, axi4_m.rid};

    w_state_t w_state, w_state_n;
    r_state_t r_state, r_state_n;
    logic w_g, w_g_n, w_last, w_last_n, aw_done, aw_done_n, w_done, w_done_n;
    logic r_g, r_g_n, r_last, r_last_n;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;

    assign w_fsm = w_state;
    assign r_fsm = r_state;

    // Downstream request side: only the granted port is visible, and each
    // address/data channel is suppressed once it has been accepted.
    assign m_awvalid = (w_state == W_XFER) && s_awvalid[w_g] && !aw_done;
    assign m_wvalid  = (w_state == W_XFER) && s_wvalid[w_g] && !w_done;
    assign m_bready  = (w_state == W_RESP) && s_bready[w_g];
    assign m_arvalid = (r_state == R_ADDR) && s_arvalid[r_g];
    assign m_rready  = (r_state == R_DATA) && s_rready[r_g];

    assign axi4_m.awvalid = m_awvalid;
    assign axi4_m.awaddr  = s_awaddr[w_g];
    assign axi4_m.awprot  = s_awprot[w_g];
    assign axi4_m.awid    = {I{1'b0}};
    assign axi4_m.wvalid  = m_wvalid;
    assign axi4_m.wdata   = s_wdata[w_g];
    assign axi4_m.wstrb   = s_wstrb[w_g];
    assign axi4_m.bready  = m_bready;
    assign axi4_m.arvalid = m_arvalid;
    assign axi4_m.araddr  = s_araddr[r_g];
    assign axi4_m.arprot  = s_arprot[r_g];
    assign axi4_m.arid    = {I{1'b0}};
    assign axi4_m.rready  = m_rready;

    assign aw_hs = m_awvalid && axi4_m.awready;
    assign w_hs  = m_wvalid && axi4_m.wready;
    assign b_hs  = axi4_m.bvalid && m_bready;
    assign ar_hs = m_arvalid && axi4_m.arready;
    assign r_hs  = axi4_m.rvalid && m_rready;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            s_awready[i] = 1'b0;
            s_wready[i]  = 1'b0;
            s_bvalid[i]  = 1'b0;
            s_bresp[i]   = 2'b00;
            s_arready[i] = 1'b0;
            s_rvalid[i]  = 1'b0;
            s_rdata[i]   = '0;
            s_rresp[i]   = 2'b00;
            if (w_g == 1'(i)) begin
                s_awready[i] = (w_state == W_XFER) && axi4_m.awready && !aw_done;
                s_wready[i]  = (w_state == W_XFER) && axi4_m.wready && !w_done;
                if (w_state == W_RESP) begin
                    s_bvalid[i] = axi4_m.bvalid;
                    s_bresp[i]  = axi4_m.bresp;
                end
            end
            if (r_g == 1'(i)) begin
                s_arready[i] = (r_state == R_ADDR) && axi4_m.arready;
                if (r_state == R_DATA) begin
                    s_rvalid[i] = axi4_m.rvalid;
                    s_rdata[i]  = axi4_m.rdata;
                    s_rresp[i]  = axi4_m.rresp;
                end
            end
        end
    end

    // Ties go to the port that did not win last; a lone requester always wins.
    always_comb begin
        w_state_n = w_state;
        w_g_n     = w_g;
        w_last_n  = w_last;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        case (w_state)
            W_IDLE: begin
                if (s_awvalid[0] || s_wvalid[0] || s_awvalid[1] || s_wvalid[1]) begin
                    if ((s_awvalid[0] || s_wvalid[0]) && (s_awvalid[1] || s_wvalid[1]))
                        w_g_n = ~w_last;
                    else
                        w_g_n = s_awvalid[1] || s_wvalid[1];
                    w_state_n = W_XFER;
                end
            end
            W_XFER: begin
                if (aw_hs) aw_done_n = 1'b1;
                if (w_hs)  w_done_n  = 1'b1;
                if (aw_done_n && w_done_n) w_state_n = W_RESP;
            end
            W_RESP: begin
                if (b_hs) begin
                    w_state_n = W_IDLE;
                    w_last_n  = w_g;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_n = r_state;
        r_g_n     = r_g;
        r_last_n  = r_last;
        case (r_state)
            R_IDLE: begin
                if (s_arvalid[0] || s_arvalid[1]) begin
                    r_g_n     = (s_arvalid[0] && s_arvalid[1]) ? ~r_last : s_arvalid[1];
                    r_state_n = R_ADDR;
                end
            end
            R_ADDR: if (ar_hs) r_state_n = R_DATA;
            R_DATA: begin
                if (r_hs) begin
                    r_state_n = R_IDLE;
                    r_last_n  = r_g;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            w_g     <= 1'b0;
            w_last  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            r_state <= R_IDLE;
            r_g     <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            w_state <= w_state_n;
            w_g     <= w_g_n;
            w_last  <= w_last_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
            r_state <= r_state_n;
            r_g     <= r_g_n;
            r_last  <= r_last_n;
        end
    end
endmodule

// File: tb/tb_axi4_lite_fanin.sv
// Directed bench for axi4_lite_fanin: two upstream initiators driven from tasks,
// a zero-latency memory responder downstream, immediate assertions at each check.
module tb_axi4_lite_fanin;
  logic clk;
  logic areset;
  logic [1:0] w_fsm;
  logic [1:0] r_fsm;

  axi4_if #(.A(16), .N(4), .I(1)) s_if [2] ();
  axi4_if #(.A(16), .N(4), .I(1)) m_if ();

  axi4_lite_fanin #(.A(16), .N(4), .I(1)) dut (
    .aclk   (clk),
    .areset (areset),
    .axi4_s (s_if),
    .axi4_m (m_if),
    .w_fsm  (w_fsm),
    .r_fsm  (r_fsm)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // upstream drive and observe arrays
  logic        up_awvalid [2];
  logic [15:0] up_awaddr  [2];
  logic        up_wvalid  [2];
  logic [31:0] up_wdata   [2];
  logic [3:0]  up_wstrb   [2];
  logic        up_bready  [2];
  logic        up_arvalid [2];
  logic [15:0] up_araddr  [2];
  logic        up_rready  [2];
  logic        up_awready [2];
  logic        up_wready  [2];
  logic        up_bvalid  [2];
  logic [1:0]  up_bresp   [2];
  logic        up_arready [2];
  logic        up_rvalid  [2];
  logic [31:0] up_rdata   [2];
  logic [1:0]  up_rresp   [2];

  for (genvar i = 0; i < 2; i++) begin : g_up
    assign s_if[i].awid    = 1'b0;
    assign s_if[i].awprot  = 3'b000;
    assign s_if[i].awvalid = up_awvalid[i];
    assign s_if[i].awaddr  = up_awaddr[i];
    assign s_if[i].wvalid  = up_wvalid[i];
    assign s_if[i].wdata   = up_wdata[i];
    assign s_if[i].wstrb   = up_wstrb[i];
    assign s_if[i].bready  = up_bready[i];
    assign s_if[i].arid    = 1'b0;
    assign s_if[i].arprot  = 3'b000;
    assign s_if[i].arvalid = up_arvalid[i];
    assign s_if[i].araddr  = up_araddr[i];
    assign s_if[i].rready  = up_rready[i];
    assign up_awready[i] = s_if[i].awready;
    assign up_wready[i]  = s_if[i].wready;
    assign up_bvalid[i]  = s_if[i].bvalid;
    assign up_bresp[i]   = s_if[i].bresp;
    assign up_arready[i] = s_if[i].arready;
    assign up_rvalid[i]  = s_if[i].rvalid;
    assign up_rdata[i]   = s_if[i].rdata;
    assign up_rresp[i]   = s_if[i].rresp;
  end

  // downstream zero-latency memory responder
  logic [31:0] mem [64];
  logic        sl_bvalid, sl_rvalid;
  logic [31:0] sl_rdata;
  logic        aw_got, w_got;
  logic [15:0] aw_a;
  logic [31:0] w_d;
  int          dn_aw_cnt, dn_w_cnt;

  assign m_if.awready = 1'b1;
  assign m_if.wready  = 1'b1;
  assign m_if.bvalid  = sl_bvalid;
  assign m_if.bresp   = 2'b00;
  assign m_if.bid     = 1'b0;
  assign m_if.arready = ~sl_rvalid;
  assign m_if.rvalid  = sl_rvalid;
  assign m_if.rdata   = sl_rdata;
  assign m_if.rresp   = 2'b00;
  assign m_if.rid     = 1'b0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    aw_got = 1'b0; w_got = 1'b0; aw_a = '0; w_d = '0;
    dn_aw_cnt = 0; dn_w_cnt = 0;
  end

  always @(posedge clk) begin
    if (areset) begin
      aw_got = 1'b0;
      w_got = 1'b0;
      sl_bvalid <= 1'b0;
      sl_rvalid <= 1'b0;
      sl_rdata <= '0;
    end else begin
      if (m_if.awvalid && m_if.awready) begin aw_got = 1'b1; aw_a = m_if.awaddr; dn_aw_cnt++; end
      if (m_if.wvalid && m_if.wready) begin w_got = 1'b1; w_d = m_if.wdata; dn_w_cnt++; end
      if (aw_got && w_got) begin
        mem[aw_a[7:2]] = w_d;
        aw_got = 1'b0;
        w_got = 1'b0;
        sl_bvalid <= 1'b1;
      end else if (sl_bvalid && m_if.bready) sl_bvalid <= 1'b0;
      if (m_if.arvalid && m_if.arready) begin
        sl_rvalid <= 1'b1;
        sl_rdata <= mem[m_if.araddr[7:2]];
      end else if (sl_rvalid && m_if.rready) sl_rvalid <= 1'b0;
    end
  end

  // upstream monitor: grant order, handshake cycle stamps, valid counts
  int cyc_n;
  int grant_q [$];
  int t_aw [2];
  int t_b  [2];
  int t_r  [2];
  int bv_cnt [2];
  int rv_cnt [2];
  int nb [2];

  initial begin
    cyc_n = 0;
    for (int p = 0; p < 2; p++) begin
      t_aw[p] = 0; t_b[p] = 0; t_r[p] = 0; bv_cnt[p] = 0; rv_cnt[p] = 0; nb[p] = 0;
    end
  end

  always @(posedge clk) begin
    cyc_n++;
    if (!areset) begin
      for (int p = 0; p < 2; p++) begin
        if (up_awvalid[p] && up_awready[p]) begin grant_q.push_back(p); t_aw[p] = cyc_n; end
        if (up_bvalid[p] && up_bready[p]) begin t_b[p] = cyc_n; nb[p]++; end
        if (up_rvalid[p] && up_rready[p]) t_r[p] = cyc_n;
        if (up_bvalid[p]) bv_cnt[p]++;
        if (up_rvalid[p]) rv_cnt[p]++;
      end
    end
  end

  // scoreboard
  int checks;
  int errors;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks (entered at a negedge, return at a negedge)
  task automatic wr(input int p, input logic [15:0] a, input logic [31:0] d,
                    input int aw_dly, input int b_hold, input bit stop_at_b, output int cycles);
    int cyc;
    int hold;
    bit aw_ok, done, aw_hs, w_hs, b_hs;
    cyc = 0; hold = b_hold; aw_ok = 0; done = 0;
    up_awaddr[p] = a; up_wdata[p] = d; up_wstrb[p] = 4'hf;
    up_wvalid[p] = 1'b1;
    up_awvalid[p] = (aw_dly == 0);
    up_bready[p] = (b_hold == 0) && !stop_at_b;
    while (!done && cyc < 100) begin
      #1;
      aw_hs = up_awvalid[p] && up_awready[p];
      w_hs  = up_wvalid[p] && up_wready[p];
      b_hs  = up_bvalid[p] && up_bready[p];
      if (b_hs) check("wr_bresp", 32'(up_bresp[p]), 32'h0);
      if (stop_at_b && up_bvalid[p]) done = 1;
      if (up_bvalid[p] && !up_bready[p] && hold > 0) hold--;
      @(negedge clk);
      cyc++;
      if (aw_hs) begin aw_ok = 1; up_awvalid[p] = 1'b0; end
      if (w_hs) up_wvalid[p] = 1'b0;
      if (b_hs) begin done = 1; up_bready[p] = 1'b0; end
      if (!aw_ok && cyc >= aw_dly) up_awvalid[p] = 1'b1;
      if (!done && !stop_at_b && hold == 0) up_bready[p] = 1'b1;
    end
    check("wr_complete", 32'(done), 32'h1);
    cycles = cyc;
  endtask

  task automatic rd(input int p, input logic [15:0] a, output logic [31:0] data,
                    output logic [1:0] resp, output int cycles);
    int cyc;
    bit done, ar_hs, r_hs;
    cyc = 0; done = 0; data = '0; resp = 2'b11;
    up_araddr[p] = a; up_arvalid[p] = 1'b1; up_rready[p] = 1'b1;
    while (!done && cyc < 100) begin
      #1;
      ar_hs = up_arvalid[p] && up_arready[p];
      r_hs  = up_rvalid[p] && up_rready[p];
      if (r_hs) begin data = up_rdata[p]; resp = up_rresp[p]; end
      @(negedge clk);
      cyc++;
      if (ar_hs) up_arvalid[p] = 1'b0;
      if (r_hs) begin done = 1; up_rready[p] = 1'b0; end
    end
    check("rd_complete", 32'(done), 32'h1);
    cycles = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // directed sequence
  logic [31:0] rdat;
  logic [1:0]  rrsp;
  int c0, c1;
  int s_aw, s_w, s_b, s_bv;
  logic [31:0] d0 [8];
  logic [31:0] d1 [8];

  initial begin
    checks = 0;
    errors = 0;
    areset = 1'b1;
    for (int p = 0; p < 2; p++) begin
      up_awvalid[p] = 1'b0; up_awaddr[p] = '0; up_wvalid[p] = 1'b0; up_wdata[p] = '0;
      up_wstrb[p] = '0; up_bready[p] = 1'b0; up_arvalid[p] = 1'b0; up_araddr[p] = '0;
      up_rready[p] = 1'b0;
    end
    repeat (2) @(negedge clk);
    up_awvalid[0] = 1'b1;
    up_wvalid[1] = 1'b1;
    up_arvalid[0] = 1'b1;
    @(negedge clk);
    check("rst_w_fsm", 32'(w_fsm), 32'h0);
    check("rst_r_fsm", 32'(r_fsm), 32'h0);
    check("rst_m_awvalid", 32'(m_if.awvalid), 32'h0);
    check("rst_m_wvalid", 32'(m_if.wvalid), 32'h0);
    check("rst_m_arvalid", 32'(m_if.arvalid), 32'h0);
    check("rst_m_bready", 32'(m_if.bready), 32'h0);
    check("rst_m_rready", 32'(m_if.rready), 32'h0);
    check("rst_s0_awready", 32'(up_awready[0]), 32'h0);
    check("rst_s1_wready", 32'(up_wready[1]), 32'h0);
    check("rst_s0_arready", 32'(up_arready[0]), 32'h0);
    check("rst_s0_rdata", up_rdata[0], 32'h0);
    up_awvalid[0] = 1'b0;
    up_wvalid[1] = 1'b0;
    up_arvalid[0] = 1'b0;
    areset = 1'b0;
    @(negedge clk);

    // single port write then read, three-cycle occupancy each
    wr(0, 16'h04, 32'habba_beef, 0, 0, 0, c0);
    check("t1_wr_cycles", 32'(c0), 32'd3);
    rd(0, 16'h04, rdat, rrsp, c0);
    check("t1_rdata", rdat, 32'habba_beef);
    check("t1_rresp", 32'(rrsp), 32'h0);
    check("t1_rd_cycles", 32'(c0), 32'd3);
    check("t1_p1_bvalid_cycles", 32'(bv_cnt[1]), 32'h0);
    check("t1_p1_rvalid_cycles", 32'(rv_cnt[1]), 32'h0);

    // fresh reset, simultaneous writes to the same address
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    grant_q.delete();
    fork
      wr(0, 16'h00, 32'h1111_1111, 0, 0, 0, c0);
      wr(1, 16'h00, 32'h2222_2222, 0, 0, 0, c1);
    join
    check("t2_grants", 32'(grant_q.size()), 32'd2);
    if (grant_q.size() == 2) begin
      check("t2_first", 32'(grant_q[0]), 32'd0);
      check("t2_second", 32'(grant_q[1]), 32'd1);
    end
    rd(0, 16'h00, rdat, rrsp, c0);
    check("t2_rdata", rdat, 32'h2222_2222);

    // back-to-back writes from both ports, strict alternation, readback
    for (int k = 0; k < 8; k++) begin
      d0[k] = $urandom;
      d1[k] = $urandom;
    end
    grant_q.delete();
    fork
      begin
        for (int k = 0; k < 8; k++) wr(0, 16'(k * 4), d0[k], 0, 0, 0, c0);
      end
      begin
        for (int k = 0; k < 8; k++) wr(1, 16'(32 + k * 4), d1[k], 0, 0, 0, c1);
      end
    join
    check("t3_grants", 32'(grant_q.size()), 32'd16);
    for (int k = 0; k < 16 && k < grant_q.size(); k++) check("t3_order", 32'(grant_q[k]), 32'(k % 2));
    for (int k = 0; k < 8; k++) exp_q.push_back(d0[k]);
    for (int k = 0; k < 8; k++) exp_q.push_back(d1[k]);
    for (int k = 0; k < 16; k++) begin
      rd(0, 16'(k * 4), rdat, rrsp, c0);
      check("t3_readback", rdat, exp_q.pop_front());
    end

    // W leads AW by three cycles on port 1
    s_aw = dn_aw_cnt; s_w = dn_w_cnt; s_b = nb[1];
    up_wdata[1] = 32'h4444_0004;
    up_wstrb[1] = 4'hf;
    up_wvalid[1] = 1'b1;
    #1;
    check("t4_wready_before_grant", 32'(up_wready[1]), 32'h0);
    wr(1, 16'h40, 32'h4444_0004, 3, 0, 0, c1);
    check("t4_dn_aw", 32'(dn_aw_cnt - s_aw), 32'd1);
    check("t4_dn_w", 32'(dn_w_cnt - s_w), 32'd1);
    check("t4_b", 32'(nb[1] - s_b), 32'd1);
    rd(0, 16'h40, rdat, rrsp, c0);
    check("t4_rdata", rdat, 32'h4444_0004);

    // overlapped read on port 0 and write on port 1
    fork
      rd(0, 16'h08, rdat, rrsp, c0);
      wr(1, 16'h0c, 32'hdead_0001, 0, 0, 0, c1);
    join
    check("t5_rdata_prior", rdat, d0[2]);
    check("t5_overlap", 32'(t_r[0]), 32'(t_b[1]));
    rd(0, 16'h0c, rdat, rrsp, c0);
    check("t5_rdata_new", rdat, 32'hdead_0001);

    // bready backpressure on port 0 blocks port 1, then reset in port 1's response phase
    s_bv = bv_cnt[0];
    fork
      wr(0, 16'h10, 32'h5555_0010, 0, 5, 0, c0);
      begin
        @(negedge clk);
        wr(1, 16'h14, 32'h6666_0014, 0, 0, 1, c1);
      end
    join
    check("t6_p0_bvalid_cycles", 32'(bv_cnt[0] - s_bv), 32'd6);
    check("t6_p1_aw_after_p0_b", 32'(t_aw[1] > t_b[0]), 32'h1);
    check("t6_w_resp", 32'(w_fsm), 32'h2);
    check("t6_p1_bvalid", 32'(up_bvalid[1]), 32'h1);
    areset = 1'b1;
    @(negedge clk);
    check("t6_rst_w_fsm", 32'(w_fsm), 32'h0);
    check("t6_rst_r_fsm", 32'(r_fsm), 32'h0);
    check("t6_rst_p1_bvalid", 32'(up_bvalid[1]), 32'h0);
    check("t6_rst_m_bready", 32'(m_if.bready), 32'h0);
    check("t6_rst_m_awvalid", 32'(m_if.awvalid), 32'h0);
    check("t6_rst_m_wvalid", 32'(m_if.wvalid), 32'h0);
    check("t6_rst_m_bvalid", 32'(m_if.bvalid), 32'h0);
    check("t6_rst_awready", 32'(up_awready[0] | up_awready[1]), 32'h0);
    areset = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
